adder_share_seq: RTL and testbench

- Shared-adder scheduler: two requesters issue W-bit add operations; the block arbitrates round-robin and executes each operation on a single K-bit adder slice, sequenced over W/K cycles with carry chaining.
- Lets multiple datapath clients share one narrow adder instead of instantiating full-width adders per client.
- Produces a (W+1)-bit sum (carry-out in MSB) plus a signed overflow flag, same result format as the existing full-width adders.

---
 rtl/adder_share_seq_if.sv | 30 +++
 rtl/adder_share_seq.sv | 141 ++++++++++++++
 tb/tb_adder_share_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/adder_share_seq_if.sv
// Request/operand/result bundle between two add requesters and the shared-adder scheduler.
// Handshake: reqN is held with AN/BN stable until grantN pulses; S/overflow/done_id are meaningful only while done is high.
interface adder_share_seq_if #(
    parameter int W = 16
);
    logic         req0;
    logic [W-1:0] A0;
    logic [W-1:0] B0;
    logic         req1;
    logic [W-1:0] A1;
    logic [W-1:0] B1;
    logic         grant0;
    logic         grant1;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W:0]   S;
    logic         overflow;
    logic [1:0]   state_dbg;

    modport master (
        output req0, A0, B0, req1, A1, B1,
        input  grant0, grant1, busy, done, done_id, S, overflow, state_dbg
    );

    modport slave (
        input  req0, A0, B0, req1, A1, B1,
        output grant0, grant1, busy, done, done_id, S, overflow, state_dbg
    );
endinterface

// File: rtl/adder_share_seq.sv
// Round-robin scheduler sharing one K-bit adder slice between two requesters;
// each W-bit add is rippled over W/K cycles with the carry held in a flop.
module adder_share_seq #(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    adder_share_seq_if.slave  bus
);
    localparam int NSLICE = W / K;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    s_q, s_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          done_id_q, done_id_d;
    logic          ovf_q, ovf_d;
    logic          grant0_q, grant0_d;
    logic          grant1_q, grant1_d;

    logic [31:0]   base;
    logic [W-1:0]  a_shift;
    logic [W-1:0]  b_shift;
    logic [K-1:0]  a_sl;
    logic [K-1:0]  b_sl;
    logic [K:0]    sum_w;
    logic          win;

    always_comb begin
        base    = 32'(idx_q) * 32'(K);
        a_shift = a_q >> base;
        b_shift = b_q >> base;
        a_sl    = a_shift[K-1:0];
        b_sl    = b_shift[K-1:0];
        sum_w   = {1'b0, a_sl} + {1'b0, b_sl} + {{K{1'b0}}, carry_q};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        last_d    = last_q;
        owner_d   = owner_q;
        done_id_d = done_id_q;
        ovf_d     = ovf_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        win       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not served last time wins.
                    win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    a_d      = win ? bus.A1 : bus.A0;
                    b_d      = win ? bus.B1 : bus.B0;
                    owner_d  = win;
                    last_d   = win;
                    carry_d  = 1'b0;
                    idx_d    = '0;
                    grant0_d = ~win;
                    grant1_d = win;
                    state_d  = RUN;
                end
            end
            RUN: begin
                s_d[base +: K] = sum_w[K-1:0];
                carry_d        = sum_w[K];
                idx_d          = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    // Carry into the sign bit is recovered from the top bit's inputs and sum.
                    s_d[W]    = sum_w[K];
                    ovf_d     = a_sl[K-1] ^ b_sl[K-1] ^ sum_w[K-1] ^ sum_w[K];
                    done_id_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            done_id_q <= 1'b0;
            ovf_q     <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            done_id_q <= done_id_d;
            ovf_q     <= ovf_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
        end
    end

    assign bus.grant0    = grant0_q;
    assign bus.grant1    = grant1_q;
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.done_id   = done_id_q;
    assign bus.S         = s_q;
    assign bus.overflow  = ovf_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_adder_share_seq.sv
// Directed bench for adder_share_seq (W=16, K=4): single adds, carry/overflow corners,
// round-robin alternation, mid-operation reset and a request pulsed during RUN.
module tb_adder_share_seq;
    localparam int W = 16;
    localparam int K = 4;

    logic clk;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [W+1:0] exp_q[$];

    adder_share_seq_if #(.W(W)) bus ();

    adder_share_seq #(.W(W), .K(K)) dut (
        .Clock  (clk),
        .Resetn (resetn),
        .bus    (bus)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        resetn   = 1'b0;
        tick();
        tick();
        resetn   = 1'b1;
    endtask

    task automatic single_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W:0] exp_s, input logic exp_ovf);
        int cyc;
        if (id) begin
            bus.A1 = a; bus.B1 = b; bus.req1 = 1'b1;
        end else begin
            bus.A0 = a; bus.B0 = b; bus.req0 = 1'b1;
        end
        tick();
        check("op_grant_mine",  {31'b0, (id ? bus.grant1 : bus.grant0)}, 32'd1);
        check("op_grant_other", {31'b0, (id ? bus.grant0 : bus.grant1)}, 32'd0);
        check("op_busy",        {31'b0, bus.busy}, 32'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 10) begin
            tick();
            cyc++;
        end
        check("op_latency",  cyc, 4);
        check("op_S",        {15'b0, bus.S}, {15'b0, exp_s});
        check("op_overflow", {31'b0, bus.overflow}, {31'b0, exp_ovf});
        check("op_done_id",  {31'b0, bus.done_id}, {31'b0, id});
        tick();
        check("op_done_drop", {31'b0, bus.done}, 32'd0);
        check("op_idle_busy", {31'b0, bus.busy}, 32'd0);
    endtask

    // Directed sequence with scoreboard and final report
    initial begin
        int ng, nd, cyc_prev, ndone, ngr;
        logic g;
        logic [W+1:0] e;

        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        do_reset();
        check("rst_grant0",   {31'b0, bus.grant0}, 32'd0);
        check("rst_grant1",   {31'b0, bus.grant1}, 32'd0);
        check("rst_busy",     {31'b0, bus.busy}, 32'd0);
        check("rst_done",     {31'b0, bus.done}, 32'd0);
        check("rst_done_id",  {31'b0, bus.done_id}, 32'd0);
        check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        check("rst_S",        {15'b0, bus.S}, 32'd0);
        check("rst_state",    {30'b0, bus.state_dbg}, 32'd0);

        single_op(1'b0, 16'h1234, 16'h0001, 17'h01235, 1'b0);
        single_op(1'b1, 16'h0FFF, 16'h0001, 17'h01000, 1'b0);
        single_op(1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0);
        single_op(1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1);
        single_op(1'b1, 16'h8000, 16'h8000, 17'h10000, 1'b1);

        // Both requesters held high: expect 0,1,0,1 with captures 6 cycles apart.
        do_reset();
        bus.A0 = 16'h1111; bus.B0 = 16'h2222;
        bus.A1 = 16'hF000; bus.B1 = 16'h1000;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        ng = 0; nd = 0; cyc_prev = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            tick();
            check("alt_no_dual_grant", {31'b0, bus.grant0 & bus.grant1}, 32'd0);
            if (bus.grant0 || bus.grant1) begin
                g = bus.grant1;
                check("alt_grant_order", {31'b0, g}, ng % 2);
                if (ng > 0) check("alt_grant_gap", c - cyc_prev, 6);
                cyc_prev = c;
                ng++;
                exp_q.push_back(g ? {1'b1, 17'h10000} : {1'b0, 17'h03333});
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("alt_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("alt_S",       {15'b0, bus.S}, {15'b0, e[W:0]});
                    check("alt_done_id", {31'b0, bus.done_id}, {31'b0, e[W+1]});
                end
                nd++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("alt_done_count",  nd, 4);
        check("alt_grant_count", ng, 4);
        check("alt_queue_empty", exp_q.size(), 0);

        // Reset asserted at E2 of an operation aborts it.
        do_reset();
        bus.A0 = 16'h1111; bus.B0 = 16'h1111; bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("abort_done",  {31'b0, bus.done}, 32'd0);
        check("abort_S",     {15'b0, bus.S}, 32'd0);
        check("abort_busy",  {31'b0, bus.busy}, 32'd0);
        check("abort_state", {30'b0, bus.state_dbg}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        single_op(1'b0, 16'h0003, 16'h0004, 17'h00007, 1'b0);

        // A request pulsed while RUN is never granted.
        bus.A0 = 16'h0010; bus.B0 = 16'h0020; bus.req0 = 1'b1;
        tick();
        check("pulse_first_grant", {31'b0, bus.grant0}, 32'd1);
        bus.req0 = 1'b0;
        tick();
        bus.A0 = 16'h5555; bus.B0 = 16'h5555; bus.req0 = 1'b1;
        tick();
        tick();
        bus.req0 = 1'b0;
        ndone = 0; ngr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.grant0 || bus.grant1) ngr++;
            if (bus.done) begin
                ndone++;
                check("pulse_S", {15'b0, bus.S}, 32'h00030);
            end
        end
        check("pulse_done_count",  ndone, 1);
        check("pulse_grant_count", ngr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
